// File: rtl/avalon_lsu_pkg.sv
// Shared types for the Avalon load/store unit.
// Size codes, FSM states and the alignment rule.
package avalon_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUS     = 2'b01,
    CAPTURE = 2'b10
  } lsu_state_t;

  // Size code 2'b11 is handled as a word.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    if (size == SIZE_BYTE)
      m = 1'b0;
    else if (size == SIZE_HALF)
      m = lo[0];
    else
      m = (lo != 2'b00);
    return m;
  endfunction

endpackage

// File: rtl/avalon_lsu_lane.sv
// Little-endian lane steering for stores and
// lane extraction plus extension for loads.
module lsu_lane
  import avalon_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] readdata_i,
  output logic [3:0]  byteenable_o,
  output logic [31:0] writedata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  b;
  logic [15:0] h;

  // Lane select and extension; sizes other than byte/half act as word.
  always_comb begin
    byteenable_o = 4'b1111;
    writedata_o  = wdata_i;
    rdata_o      = readdata_i;
    b            = readdata_i[8*addr_lo_i +: 8];
    h            = addr_lo_i[1] ? readdata_i[31:16]
                                : readdata_i[15:0];
    if (size_i == SIZE_BYTE) begin
      byteenable_o = 4'b0001 << addr_lo_i;
      writedata_o  = {4{wdata_i[7:0]}};
      rdata_o      = {{24{sign_i & b[7]}}, b};
    end else if (size_i == SIZE_HALF) begin
      byteenable_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      writedata_o  = {2{wdata_i[15:0]}};
      rdata_o      = {{16{sign_i & h[15]}}, h};
    end
  end

endmodule

// File: rtl/avalon_lsu.sv
// Load/store unit driving an Avalon-MM master port.
// One request at a time, waitrequest stalls, optional bus timeout.
module avalon_lsu
  import avalon_lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        timeout_o,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  input  logic        waitrequest_i,
  output logic [31:0] writedata_o,
  output logic [3:0]  byteenable_o,
  input  logic [31:0] readdata_i
);

  localparam logic [31:0] TO_LAST =
    (BUS_TIMEOUT == 0) ? 32'd0 : 32'(BUS_TIMEOUT - 1);

  lsu_state_t  state_q, state_d;
  logic        we_q, sign_q;
  logic [1:0]  size_q, lo_q;
  logic [31:0] addr_q, wd_q, rdata_q;
  logic [3:0]  be_q;
  logic [31:0] cnt_q;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;

  logic        req_mis, start, to_hit;
  logic [1:0]  lane_lo, lane_size;
  logic [3:0]  lane_be;
  logic [31:0] lane_wd, lane_rd;

  assign req_mis   = misaligned(size_i, addr_i[1:0]);
  assign start     = (state_q == IDLE) && req_i && !req_mis;
  assign to_hit    = (BUS_TIMEOUT != 0) && waitrequest_i &&
                     (cnt_q == TO_LAST);
  // Lanes see the live request in IDLE and the latched one afterwards.
  assign lane_lo   = (state_q == IDLE) ? addr_i[1:0] : lo_q;
  assign lane_size = (state_q == IDLE) ? size_i : size_q;

  lsu_lane u_lane (
    .addr_lo_i   (lane_lo),
    .size_i      (lane_size),
    .sign_i      (sign_q),
    .wdata_i     (wdata_i),
    .readdata_i  (readdata_i),
    .byteenable_o(lane_be),
    .writedata_o (lane_wd),
    .rdata_o     (lane_rd)
  );

  // State and completion pulse registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  // Next state and completion flags.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (req_mis) begin
            done_d = 1'b1;
            mis_d  = 1'b1;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (!waitrequest_i) begin
          if (we_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
        end else if (to_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
          to_d    = 1'b1;
        end
      end
      CAPTURE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Avalon strobes and busy decode from state.
  always_comb begin
    busy_o  = (state_q != IDLE);
    read_o  = (state_q == BUS) && !we_q;
    write_o = (state_q == BUS) && we_q;
  end

  // Request latches, load result and wait counter.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
      lo_q    <= 2'b00;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      be_q    <= 4'b0000;
      rdata_q <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      if (start) begin
        we_q   <= we_i;
        sign_q <= sign_ext_i;
        size_q <= size_i;
        lo_q   <= addr_i[1:0];
        addr_q <= {addr_i[31:2], 2'b00};
        wd_q   <= lane_wd;
        be_q   <= lane_be;
      end
      if (state_q == CAPTURE)
        rdata_q <= lane_rd;
      if ((state_q == BUS) && waitrequest_i)
        cnt_q <= cnt_q + 32'd1;
      else
        cnt_q <= 32'd0;
    end
  end

  assign done_o       = done_q;
  assign misaligned_o = mis_q;
  assign timeout_o    = to_q;
  assign rdata_o      = rdata_q;
  assign address_o    = addr_q;
  assign writedata_o  = wd_q;
  assign byteenable_o = be_q;

endmodule

// File: tb/tb_avalon_lsu.sv
// Self-checking bench for avalon_lsu.
// Directed cases then random transactions against a behavioural model.
module tb_avalon_lsu;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [1:0]  size_i;
  logic        sign_ext_i;
  logic [31:0] wdata_i;
  logic        busy_o, done_o, misaligned_o, timeout_o;
  logic [31:0] rdata_o, address_o, writedata_o;
  logic        read_o, write_o;
  logic        waitrequest_i;
  logic [3:0]  byteenable_o;
  logic [31:0] readdata_i;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] m_rdata = 32'd0;

  always #5 clk = ~clk;

  avalon_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .size_i       (size_i),
    .sign_ext_i   (sign_ext_i),
    .wdata_i      (wdata_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .misaligned_o (misaligned_o),
    .timeout_o    (timeout_o),
    .address_o    (address_o),
    .read_o       (read_o),
    .write_o      (write_o),
    .waitrequest_i(waitrequest_i),
    .writedata_o  (writedata_o),
    .byteenable_o (byteenable_o),
    .readdata_i   (readdata_i)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(
    input logic [31:0] a, input logic [1:0] sz,
    input logic sg, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (a[1:0] * 8)) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (a[1] * 16)) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Called at a negedge with the unit idle; returns at the done negedge.
  task automatic txn(input logic we, input logic [31:0] a,
                     input logic [1:0] sz, input logic sg,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int nwait);
    logic        mis;
    logic [31:0] e_be, e_wd;
    int          nbus;
    mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
    if (sz == 2'd0) begin
      e_be = 32'd1 << a[1:0];
      e_wd = 32'h0101_0101 * wd[7:0];
    end else if (sz == 2'd1) begin
      e_be = a[1] ? 32'hC : 32'h3;
      e_wd = 32'h0001_0001 * wd[15:0];
    end else begin
      e_be = 32'hF;
      e_wd = wd;
    end
    req_i = 1'b1; we_i = we; addr_i = a; size_i = sz;
    sign_ext_i = sg; wdata_i = wd;
    @(negedge clk);
    req_i = 1'b0;
    addr_i = $urandom; wdata_i = $urandom;
    size_i = 2'($urandom); sign_ext_i = 1'($urandom);
    if (mis) begin
      chk("mis_done", {31'd0, done_o}, 32'd1);
      chk("mis_flag", {31'd0, misaligned_o}, 32'd1);
      chk("mis_strobe", {30'd0, read_o, write_o}, 32'd0);
      chk("mis_busy", {31'd0, busy_o}, 32'd0);
      chk("mis_rdata", rdata_o, m_rdata);
      return;
    end
    nbus = (nwait >= 4) ? 4 : nwait + 1;
    for (int i = 0; i < nbus; i++) begin
      chk("bus_busy", {31'd0, busy_o}, 32'd1);
      chk("bus_done", {31'd0, done_o}, 32'd0);
      chk("bus_read", {31'd0, read_o}, {31'd0, !we});
      chk("bus_write", {31'd0, write_o}, {31'd0, we});
      chk("bus_addr", address_o, a & 32'hFFFF_FFFC);
      chk("bus_be", {28'd0, byteenable_o}, e_be);
      chk("bus_wd", writedata_o, e_wd);
      waitrequest_i = (i < nwait);
      readdata_i = $urandom;
      @(negedge clk);
    end
    waitrequest_i = 1'b0;
    if (nwait >= 4) begin
      chk("to_done", {31'd0, done_o}, 32'd1);
      chk("to_flag", {31'd0, timeout_o}, 32'd1);
      chk("to_busy", {31'd0, busy_o}, 32'd0);
      chk("to_strobe", {30'd0, read_o, write_o}, 32'd0);
      chk("to_rdata", rdata_o, m_rdata);
      return;
    end
    if (!we) begin
      chk("cap_strobe", {30'd0, read_o, write_o}, 32'd0);
      chk("cap_busy", {31'd0, busy_o}, 32'd1);
      chk("cap_done", {31'd0, done_o}, 32'd0);
      readdata_i = rd;
      @(negedge clk);
      readdata_i = $urandom;
      m_rdata = exp_load(a, sz, sg, rd);
    end
    chk("done", {31'd0, done_o}, 32'd1);
    chk("busy_end", {31'd0, busy_o}, 32'd0);
    chk("rdata", rdata_o, m_rdata);
    chk("flags", {30'd0, misaligned_o, timeout_o}, 32'd0);
  endtask

  initial begin
    reset_i = 1'b1; req_i = 1'b0; we_i = 1'b0;
    addr_i = 32'd0; size_i = 2'd0; sign_ext_i = 1'b0;
    wdata_i = 32'd0; waitrequest_i = 1'b0; readdata_i = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_pulse", {29'd0, done_o, misaligned_o, timeout_o}, 32'd0);
    chk("rst_strobe", {30'd0, read_o, write_o}, 32'd0);
    chk("rst_addr", address_o, 32'd0);
    chk("rst_wd", writedata_o, 32'd0);
    chk("rst_be", {28'd0, byteenable_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    txn(1'b0, 32'h0000_1004, 2'd2, 1'b0, 32'd0, 32'hDEAD_BEEF, 0);
    txn(1'b0, 32'h0000_1007, 2'd0, 1'b1, 32'd0, 32'h8000_0000, 0);
    txn(1'b0, 32'h0000_1007, 2'd0, 1'b0, 32'd0, 32'h8000_0000, 0);
    txn(1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_ABCD, 32'd0, 3);
    txn(1'b0, 32'h0000_3001, 2'd2, 1'b0, 32'd0, 32'h1234_5678, 0);
    txn(1'b0, 32'h0000_4000, 2'd2, 1'b0, 32'd0, 32'h1111_1111, 4);
    txn(1'b1, 32'h0000_4002, 2'd1, 1'b0, 32'h5555, 32'd0, 6);

    // Reset during the second BUS cycle of a load.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_5000;
    size_i = 2'd2; sign_ext_i = 1'b0;
    @(negedge clk);
    req_i = 1'b0; waitrequest_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0; waitrequest_i = 1'b0;
    m_rdata = 32'd0;
    chk("mrst_read", {31'd0, read_o}, 32'd0);
    chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    chk("mrst_done", {31'd0, done_o}, 32'd0);
    chk("mrst_rdata", rdata_o, 32'd0);
    @(negedge clk);
    chk("mrst_nodone", {31'd0, done_o}, 32'd0);
    txn(1'b0, 32'h0000_6002, 2'd1, 1'b1, 32'd0, 32'hF00D_0000, 1);
    txn(1'b0, 32'h0000_6001, 2'd0, 1'b1, 32'd0, 32'h0000_7F00, 0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'd0;
      txn(1'($urandom), a, 2'($urandom), 1'($urandom),
          $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/avalon_lsu.md
Name: avalon_lsu

Overview:
Load/store unit sitting between the multicycle core datapath (control/regfile/ALU) and the Avalon-MM master port of mips_cpu_bus. It accepts one memory request at a time from the core and runs the Avalon handshake, including waitrequest stalls. It performs little-endian byte/half/word lane alignment and byteenable generation, and sign/zero-extends sub-word load data. Its busy_o feeds the top-level stall OR, together with the ALU stall.

Parameters:
BUS_TIMEOUT, 0, consecutive BUS-state cycles with waitrequest_i=1 before abort; 0 disables the timeout.

Ports:
clk  in  1  clock
reset_i  in  1  reset
req_i  in  1  start request; sampled only in IDLE
we_i  in  1  1=store, 0=load
addr_i  in  32  byte address
size_i  in  2  mem_size_t: 00 byte, 01 half, 10 word; 11 treated as word
sign_ext_i  in  1  loads: 1=sign-extend, 0=zero-extend
wdata_i  in  32  store data, right-justified
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
rdata_o  out  32  extended load result, held until the next load completes
misaligned_o  out  1  pulses with done_o on an alignment fault
timeout_o  out  1  pulses with done_o on a bus timeout
address_o  out  32  {addr[31:2],2'b00}
read_o  out  1  Avalon read
write_o  out  1  Avalon write
waitrequest_i  in  1  Avalon waitrequest
writedata_o  out  32  lane-replicated store data
byteenable_o  out  4  active lanes
readdata_i  in  32  Avalon readdata, valid the cycle after an accepted read

Behaviour:
- One clock domain. Reset is synchronous and active-high, applied on the clk edge while reset_i=1.
- Reset values: state=IDLE; done_o, misaligned_o, timeout_o, read_o, write_o = 0; rdata_o, address_o, writedata_o = 0; byteenable_o=4'b0000.
- A reset mid-transaction aborts it: strobes are low from the reset edge, no done_o pulse, and rdata_o is cleared.
- States (lsu_state_t): IDLE, BUS, CAPTURE.
- IDLE with req_i=1, aligned: latch address_o, byteenable_o, writedata_o, we and size/sign; go to BUS.
- IDLE with req_i=1, misaligned (half with addr[0]=1, or word with addr[1:0]!=0): no bus cycle, stay in IDLE; done_o=1 and misaligned_o=1 next cycle; rdata_o unchanged.
- BUS: read_o=!we, write_o=we. Address, writedata and byteenable stay stable while waitrequest_i=1.
- BUS exit on a cycle with waitrequest_i=0: load goes to CAPTURE; store goes to IDLE with done_o=1 next cycle.
- CAPTURE: strobes low. At the end of this cycle, extract lanes from readdata_i into rdata_o; go to IDLE with done_o=1 next cycle.
- Latency, request at cycle N with k≥1 BUS cycles: store done at N+k+1; load done and rdata_o valid at N+k+2. Zero-wait load: done at N+3.
- Timeout (BUS_TIMEOUT>0): on the BUS_TIMEOUT-th consecutive waitrequest_i=1 cycle, drop strobes and go to IDLE. done_o=1 and timeout_o=1 next cycle; rdata_o unchanged.
- req_i is ignored while busy. A req_i in the same cycle done_o=1 is accepted, because the unit is in IDLE.
- Lanes (little-endian, k=addr[1:0]):
  - byte: byteenable 1<<k; writedata_o={4{wdata[7:0]}}; load uses readdata[8k+7:8k].
  - half: addr[1]=0 gives 0011, =1 gives 1100; writedata_o={2{wdata[15:0]}}; load uses the matching 16 bits.
  - word: 1111, pass-through.
- Extension: sign_ext_i=1 replicates the top bit of the extracted field, else zero-fills. Word loads ignore sign_ext_i.

Decomposition:
- Package codes gets:
  - mem_size_t (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10)
  - lsu_state_t (IDLE, BUS, CAPTURE)
- One combinational sub-module, lsu_lane: (addr[1:0], size, wdata) to (byteenable, writedata), and (readdata, addr[1:0], size, sign) to extended rdata.
- The FSM, latches and timeout counter live in avalon_lsu.

Test Plan:
- Word load, addr 0x0000_1004, waitrequest 0, readdata 0xDEADBEEF → read_o one cycle, address_o 0x1004, byteenable 1111; done at N+3 with rdata_o=0xDEADBEEF.
- Signed byte load, addr 0x1007, readdata 0x80_00_00_00 → byteenable 1000, rdata_o=0xFFFFFF80. Same load with sign_ext_i=0 → 0x00000080.
- Half store, addr 0x2002, wdata 0x0000ABCD, waitrequest high 3 cycles → write_o held 4 cycles, writedata 0xABCDABCD, byteenable 1100, address stable; done one cycle after the accept.
- Misaligned word load, addr 0x3001 → read_o/write_o never assert; done_o=misaligned_o=1 next cycle; rdata_o keeps its prior value.
- BUS_TIMEOUT=4, waitrequest stuck 1 → strobes drop after 4 BUS cycles; done_o=timeout_o=1; busy_o=0.
- reset_i asserted in the 2nd BUS cycle of a load → next cycle read_o=0, busy_o=0, rdata_o=0, no done_o pulse. A back-to-back request issued with done_o completes normally.
